// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and the dmem bus shared by dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              r0_req;
  logic              r0_we;
  logic              r0_lock;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wd;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rd;

  logic              r1_req;
  logic              r1_we;
  logic              r1_lock;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wd;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rd;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wd,
    output r0_gnt, r0_rvalid, r0_rd,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wd,
    output r1_gnt, r1_rvalid, r1_rd,
    output mem_a, mem_wd, mem_we,
    input  mem_rd
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wd,
    input  r0_gnt, r0_rvalid, r0_rd,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wd,
    input  r1_gnt, r1_rvalid, r1_rd,
    input  mem_a, mem_wd, mem_we,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port dmem between CPU (r0) and loader (r1),
// with a bounded lock for atomic read-modify-write and registered read return.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [4:0] MAX_LOCK_W = 5'(MAX_LOCK);
  localparam bit         LOCK_EN    = (MAX_LOCK > 1);

  state_t     state;
  logic       owner;
  logic       prio;
  logic [3:0] lock_cnt;

  logic [1:0] req;
  logic [1:0] lock;
  logic       gnt_vld;
  logic       gnt_id;
  logic       gnt_we;
  logic       gnt_lock;
  logic [4:0] cnt_next;

  assign req      = {bus.r1_req, bus.r0_req};
  assign lock     = {bus.r1_lock, bus.r0_lock};
  assign cnt_next = {1'b0, lock_cnt} + 5'd1;

  // Nothing is granted during reset so dmem can never be written then
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n) begin
      if (state == LOCKED) begin
        if (req[owner]) begin
          gnt_vld = 1'b1;
          gnt_id  = owner;
        end
      end else if (req == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_id  = prio;
      end else if (req[0]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req[1]) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign gnt_we   = gnt_id ? bus.r1_we : bus.r0_we;
  assign gnt_lock = lock[gnt_id];

  assign bus.r0_gnt = gnt_vld & ~gnt_id;
  assign bus.r1_gnt = gnt_vld &  gnt_id;
  assign bus.mem_we = gnt_vld & gnt_we;
  assign bus.mem_a  = !gnt_vld ? '0 : (gnt_id ? bus.r1_addr : bus.r0_addr);
  assign bus.mem_wd = !gnt_vld ? '0 : (gnt_id ? bus.r1_wd   : bus.r0_wd);

  // Lock FSM and priority; leaving LOCKED always hands the next tie to the other side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      lock_cnt <= 4'd0;
    end else if (state == LOCKED) begin
      if (gnt_vld) begin
        if (gnt_lock && (cnt_next < MAX_LOCK_W)) begin
          lock_cnt <= cnt_next[3:0];
        end else begin
          state    <= IDLE;
          lock_cnt <= 4'd0;
          prio     <= ~owner;
        end
      end else if (!lock[owner]) begin
        state    <= IDLE;
        lock_cnt <= 4'd0;
        prio     <= ~owner;
      end
    end else if (gnt_vld) begin
      prio <= ~gnt_id;
      if (gnt_lock && LOCK_EN) begin
        state    <= LOCKED;
        owner    <= gnt_id;
        lock_cnt <= 4'd1;
      end
    end
  end

  // dmem reads combinationally, so the word is captured in the grant cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r0_rvalid <= 1'b0;
      bus.r1_rvalid <= 1'b0;
      bus.r0_rd     <= '0;
      bus.r1_rd     <= '0;
    end else begin
      bus.r0_rvalid <= bus.r0_gnt & ~gnt_we;
      bus.r1_rvalid <= bus.r1_gnt & ~gnt_we;
      if (bus.r0_gnt && !gnt_we) bus.r0_rd <= bus.mem_rd;
      if (bus.r1_gnt && !gnt_we) bus.r1_rd <= bus.mem_rd;
    end
  end

endmodule
